// File: rtl/z80fi_capture_pkg.sv
// Shared types and constants for the z80fi retirement-packet capture block.
// Register index constants locate each 16-bit register inside the packed regs snapshot.
package z80fi_capture_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_CAPTURE = 1'b1
   } cap_state_t;

   localparam int INSN_MAX_BYTES = 4;
   localparam int MEM_SLOTS      = 2;

   localparam int REG_COUNT = 13;
   localparam int REG_IP    = 0;
   localparam int REG_SP    = 1;
   localparam int REG_IX    = 2;
   localparam int REG_IY    = 3;
   localparam int REG_AF    = 4;
   localparam int REG_BC    = 5;
   localparam int REG_DE    = 6;
   localparam int REG_HL    = 7;
   localparam int REG_AF2   = 8;
   localparam int REG_BC2   = 9;
   localparam int REG_DE2   = 10;
   localparam int REG_HL2   = 11;
   localparam int REG_IR    = 12;

   // Contents of one two-slot access recorder; ovf marks a third or later access.
   typedef struct packed {
      logic        used1;
      logic        used2;
      logic [15:0] addr1;
      logic [15:0] addr2;
      logic [7:0]  data1;
      logic [7:0]  data2;
      logic        ovf;
   } slot_rec_t;

   function automatic int reg_lsb(input int idx);
      return 16 * idx;
   endfunction

endpackage

// File: rtl/z80fi_access_slots.sv
// Two-slot address/data recorder: the first two strobes after a clear are kept, later ones only flag overflow.
// nxt exposes this cycle's updated contents so a retirement can include same-cycle accesses.
module z80fi_access_slots
   import z80fi_capture_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        strobe,
   input  logic [15:0] addr,
   input  logic [7:0]  data,
   output slot_rec_t   cur,
   output slot_rec_t   nxt
);

   slot_rec_t base;

   always_comb begin
      base = clear ? '0 : cur;
      nxt  = base;
      if (strobe) begin
         if (!base.used1) begin
            nxt.used1 = 1'b1;
            nxt.addr1 = addr;
            nxt.data1 = data;
         end else if (!base.used2) begin
            nxt.used2 = 1'b1;
            nxt.addr2 = addr;
            nxt.data2 = data;
         end else begin
            nxt.ovf = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cur <= '0;
      else       cur <= nxt;
   end

endmodule

// File: rtl/z80fi_insn_capture.sv
// Assembles one z80fi retirement packet per instruction from fetch, memory and register activity.
// The packet is registered and strobed by z80fi_valid one cycle after insn_done.
module z80fi_insn_capture
   import z80fi_capture_pkg::*;
#(
   parameter int REGS_W = 208
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              insn_start,
   input  logic              fetch_valid,
   input  logic [7:0]        fetch_data,
   input  logic              mem_wr,
   input  logic [15:0]       mem_waddr_in,
   input  logic [7:0]        mem_wdata_in,
   input  logic              mem_rd,
   input  logic [15:0]       mem_raddr_in,
   input  logic [7:0]        mem_rdata_in,
   input  logic              insn_done,
   input  logic [REGS_W-1:0] regs,
   output logic              z80fi_valid,
   output logic [31:0]       z80fi_insn,
   output logic [2:0]        z80fi_insn_len,
   output logic [REGS_W-1:0] z80fi_regs_in,
   output logic [REGS_W-1:0] z80fi_regs_out,
   output logic              z80fi_mem_wr,
   output logic              z80fi_mem_wr2,
   output logic [15:0]       z80fi_mem_waddr,
   output logic [15:0]       z80fi_mem_waddr2,
   output logic [7:0]        z80fi_mem_wdata,
   output logic [7:0]        z80fi_mem_wdata2,
   output logic              z80fi_mem_rd,
   output logic              z80fi_mem_rd2,
   output logic [15:0]       z80fi_mem_raddr,
   output logic [15:0]       z80fi_mem_raddr2,
   output logic [7:0]        z80fi_mem_rdata,
   output logic [7:0]        z80fi_mem_rdata2,
   output logic              z80fi_overflow,
   output logic              z80fi_dropped
);

   localparam logic [2:0] MAX_LEN = 3'(INSN_MAX_BYTES);

   cap_state_t        state_q;
   logic [31:0]       insn_q, insn_n;
   logic [2:0]        len_q, len_n;
   logic              fovf_q, fovf_n;
   logic [REGS_W-1:0] regs_in_q;
   slot_rec_t         wr_cur, wr_nxt, rd_cur, rd_nxt;
   slot_rec_t         wr_pkt, rd_pkt;
   logic [31:0]       insn_pkt;
   logic [2:0]        len_pkt;
   logic              fovf_pkt;
   logic              active, retire;

   // A start always opens a capture, even from IDLE; otherwise only CAPTURE listens.
   assign active = insn_start || (state_q == ST_CAPTURE);
   assign retire = (state_q == ST_CAPTURE) && insn_done;

   z80fi_access_slots u_wr_slots (
      .clk    (clk),
      .reset  (reset),
      .clear  (insn_start),
      .strobe (active && mem_wr),
      .addr   (mem_waddr_in),
      .data   (mem_wdata_in),
      .cur    (wr_cur),
      .nxt    (wr_nxt)
   );

   z80fi_access_slots u_rd_slots (
      .clk    (clk),
      .reset  (reset),
      .clear  (insn_start),
      .strobe (active && mem_rd),
      .addr   (mem_raddr_in),
      .data   (mem_rdata_in),
      .cur    (rd_cur),
      .nxt    (rd_nxt)
   );

   always_comb begin
      insn_n = insn_start ? '0 : insn_q;
      len_n  = insn_start ? '0 : len_q;
      fovf_n = insn_start ? 1'b0 : fovf_q;
      if (active && fetch_valid) begin
         if (len_n < MAX_LEN) begin
            insn_n[{len_n[1:0], 3'b000} +: 8] = fetch_data;
            len_n = len_n + 3'd1;
         end else begin
            fovf_n = 1'b1;
         end
      end
   end

   // On a back-to-back start the same-cycle events belong to the new instruction,
   // so the retiring packet comes from the buffer as it stood before this cycle.
   assign insn_pkt = insn_start ? insn_q : insn_n;
   assign len_pkt  = insn_start ? len_q  : len_n;
   assign fovf_pkt = insn_start ? fovf_q : fovf_n;
   assign wr_pkt   = insn_start ? wr_cur : wr_nxt;
   assign rd_pkt   = insn_start ? rd_cur : rd_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         insn_q           <= '0;
         len_q            <= '0;
         fovf_q           <= 1'b0;
         regs_in_q        <= '0;
         z80fi_valid      <= 1'b0;
         z80fi_dropped    <= 1'b0;
         z80fi_insn       <= '0;
         z80fi_insn_len   <= '0;
         z80fi_regs_in    <= '0;
         z80fi_regs_out   <= '0;
         z80fi_mem_wr     <= 1'b0;
         z80fi_mem_wr2    <= 1'b0;
         z80fi_mem_waddr  <= '0;
         z80fi_mem_waddr2 <= '0;
         z80fi_mem_wdata  <= '0;
         z80fi_mem_wdata2 <= '0;
         z80fi_mem_rd     <= 1'b0;
         z80fi_mem_rd2    <= 1'b0;
         z80fi_mem_raddr  <= '0;
         z80fi_mem_raddr2 <= '0;
         z80fi_mem_rdata  <= '0;
         z80fi_mem_rdata2 <= '0;
         z80fi_overflow   <= 1'b0;
      end else begin
         insn_q        <= insn_n;
         len_q         <= len_n;
         fovf_q        <= fovf_n;
         z80fi_valid   <= retire;
         z80fi_dropped <= (state_q == ST_CAPTURE) && insn_start && !insn_done;
         if (insn_start) regs_in_q <= regs;

         if (retire) begin
            z80fi_insn       <= insn_pkt;
            z80fi_insn_len   <= len_pkt;
            z80fi_regs_in    <= regs_in_q;
            z80fi_regs_out   <= regs;
            z80fi_mem_wr     <= wr_pkt.used1;
            z80fi_mem_wr2    <= wr_pkt.used2;
            z80fi_mem_waddr  <= wr_pkt.addr1;
            z80fi_mem_waddr2 <= wr_pkt.addr2;
            z80fi_mem_wdata  <= wr_pkt.data1;
            z80fi_mem_wdata2 <= wr_pkt.data2;
            z80fi_mem_rd     <= rd_pkt.used1;
            z80fi_mem_rd2    <= rd_pkt.used2;
            z80fi_mem_raddr  <= rd_pkt.addr1;
            z80fi_mem_raddr2 <= rd_pkt.addr2;
            z80fi_mem_rdata  <= rd_pkt.data1;
            z80fi_mem_rdata2 <= rd_pkt.data2;
            z80fi_overflow   <= fovf_pkt | wr_pkt.ovf | rd_pkt.ovf;
         end

         if (insn_start)  state_q <= ST_CAPTURE;
         else if (retire) state_q <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Self-checking bench for z80fi_insn_capture: directed test-plan scenarios followed by random cycles,
// all checked against an instruction-level model built from per-instruction event queues.
module tb_z80fi_insn_capture;
   import z80fi_capture_pkg::*;

   localparam int RW = 208;

   logic          clk = 1'b0;
   logic          reset, insn_start, fetch_valid, mem_wr, mem_rd, insn_done;
   logic [7:0]    fetch_data, mem_wdata_in, mem_rdata_in;
   logic [15:0]   mem_waddr_in, mem_raddr_in;
   logic [RW-1:0] regs;
   logic          z80fi_valid, z80fi_mem_wr, z80fi_mem_wr2, z80fi_mem_rd, z80fi_mem_rd2;
   logic          z80fi_overflow, z80fi_dropped;
   logic [31:0]   z80fi_insn;
   logic [2:0]    z80fi_insn_len;
   logic [RW-1:0] z80fi_regs_in, z80fi_regs_out;
   logic [15:0]   z80fi_mem_waddr, z80fi_mem_waddr2, z80fi_mem_raddr, z80fi_mem_raddr2;
   logic [7:0]    z80fi_mem_wdata, z80fi_mem_wdata2, z80fi_mem_rdata, z80fi_mem_rdata2;

   z80fi_insn_capture #(.REGS_W(RW)) dut (
      .clk(clk), .reset(reset), .insn_start(insn_start),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .mem_wr(mem_wr), .mem_waddr_in(mem_waddr_in), .mem_wdata_in(mem_wdata_in),
      .mem_rd(mem_rd), .mem_raddr_in(mem_raddr_in), .mem_rdata_in(mem_rdata_in),
      .insn_done(insn_done), .regs(regs),
      .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
      .z80fi_regs_in(z80fi_regs_in), .z80fi_regs_out(z80fi_regs_out),
      .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_wr2(z80fi_mem_wr2),
      .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_waddr2(z80fi_mem_waddr2),
      .z80fi_mem_wdata(z80fi_mem_wdata), .z80fi_mem_wdata2(z80fi_mem_wdata2),
      .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_rd2(z80fi_mem_rd2),
      .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_raddr2(z80fi_mem_raddr2),
      .z80fi_mem_rdata(z80fi_mem_rdata), .z80fi_mem_rdata2(z80fi_mem_rdata2),
      .z80fi_overflow(z80fi_overflow), .z80fi_dropped(z80fi_dropped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, st, fv, w, r, dn;
      logic [7:0] fb, wd, rdat;
      logic [15:0] wa, ra;
      logic [RW-1:0] rg;
   } cyc_t;

   typedef struct {
      logic [31:0] insn;
      logic [2:0] len;
      logic wr, wr2, rd, rd2, ovf;
      logic [15:0] waddr, waddr2, raddr, raddr2;
      logic [7:0] wdata, wdata2, rdata, rdata2;
      logic [RW-1:0] rin, rout;
   } pkt_t;

   typedef struct { logic [15:0] a; logic [7:0] d; } acc_t;

   int checks = 0;
   int errors = 0;

   // Model state: the events of the instruction in flight, unbounded, and the last packet.
   logic [7:0]    m_bytes[$];
   acc_t          m_wr[$];
   acc_t          m_rd[$];
   logic [RW-1:0] m_regs_in;
   bit            m_cap;
   pkt_t          last_pkt;
   logic          exp_valid, exp_drop;

   cyc_t c;
   logic [RW-1:0] r1, r2, r3;

   function automatic pkt_t zero_pkt();
      pkt_t p;
      p.insn = '0; p.len = '0; p.wr = 0; p.wr2 = 0; p.rd = 0; p.rd2 = 0; p.ovf = 0;
      p.waddr = '0; p.waddr2 = '0; p.raddr = '0; p.raddr2 = '0;
      p.wdata = '0; p.wdata2 = '0; p.rdata = '0; p.rdata2 = '0;
      p.rin = '0; p.rout = '0;
      return p;
   endfunction

   function automatic pkt_t build(input logic [RW-1:0] rout);
      pkt_t p = zero_pkt();
      for (int k = 0; k < m_bytes.size() && k < 4; k++) p.insn[8*k +: 8] = m_bytes[k];
      p.len = (m_bytes.size() > 4) ? 3'd4 : 3'(m_bytes.size());
      if (m_wr.size() >= 1) begin p.wr = 1; p.waddr = m_wr[0].a; p.wdata = m_wr[0].d; end
      if (m_wr.size() >= 2) begin p.wr2 = 1; p.waddr2 = m_wr[1].a; p.wdata2 = m_wr[1].d; end
      if (m_rd.size() >= 1) begin p.rd = 1; p.raddr = m_rd[0].a; p.rdata = m_rd[0].d; end
      if (m_rd.size() >= 2) begin p.rd2 = 1; p.raddr2 = m_rd[1].a; p.rdata2 = m_rd[1].d; end
      p.ovf = (m_bytes.size() > 4) || (m_wr.size() > 2) || (m_rd.size() > 2);
      p.rin = m_regs_in;
      p.rout = rout;
      return p;
   endfunction

   function automatic logic [RW-1:0] rand_regs();
      logic [RW-1:0] r;
      for (int k = 0; k < 6; k++) r[32*k +: 32] = $urandom;
      r[207:192] = 16'($urandom);
      return r;
   endfunction

   function automatic cyc_t idle_cyc();
      cyc_t x;
      x.rst = 0; x.st = 0; x.fv = 0; x.w = 0; x.r = 0; x.dn = 0;
      x.fb = '0; x.wd = '0; x.rdat = '0; x.wa = '0; x.ra = '0;
      x.rg = rand_regs();
      return x;
   endfunction

   task automatic record(input cyc_t x);
      acc_t e;
      if (x.fv) m_bytes.push_back(x.fb);
      if (x.w) begin e.a = x.wa; e.d = x.wd; m_wr.push_back(e); end
      if (x.r) begin e.a = x.ra; e.d = x.rdat; m_rd.push_back(e); end
   endtask

   task automatic clear_model();
      m_bytes.delete(); m_wr.delete(); m_rd.delete();
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkPacket();
      checkOutput("valid",   256'(z80fi_valid), 256'(exp_valid));
      checkOutput("dropped", 256'(z80fi_dropped), 256'(exp_drop));
      checkOutput("insn",    256'(z80fi_insn), 256'(last_pkt.insn));
      checkOutput("len",     256'(z80fi_insn_len), 256'(last_pkt.len));
      checkOutput("wr_slots", 256'({z80fi_mem_wr, z80fi_mem_wr2, z80fi_mem_waddr, z80fi_mem_wdata,
                                    z80fi_mem_waddr2, z80fi_mem_wdata2}),
                  256'({last_pkt.wr, last_pkt.wr2, last_pkt.waddr, last_pkt.wdata,
                        last_pkt.waddr2, last_pkt.wdata2}));
      checkOutput("rd_slots", 256'({z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_raddr, z80fi_mem_rdata,
                                    z80fi_mem_raddr2, z80fi_mem_rdata2}),
                  256'({last_pkt.rd, last_pkt.rd2, last_pkt.raddr, last_pkt.rdata,
                        last_pkt.raddr2, last_pkt.rdata2}));
      checkOutput("overflow", 256'(z80fi_overflow), 256'(last_pkt.ovf));
      checkOutput("regs_in",  256'(z80fi_regs_in), 256'(last_pkt.rin));
      checkOutput("regs_out", 256'(z80fi_regs_out), 256'(last_pkt.rout));
   endtask

   // Drive one cycle, advance the model at the clock edge, then check all outputs.
   task automatic applyStimulus(input cyc_t x);
      reset = x.rst; insn_start = x.st; fetch_valid = x.fv; fetch_data = x.fb;
      mem_wr = x.w; mem_waddr_in = x.wa; mem_wdata_in = x.wd;
      mem_rd = x.r; mem_raddr_in = x.ra; mem_rdata_in = x.rdat;
      insn_done = x.dn; regs = x.rg;
      @(posedge clk);
      exp_valid = 0;
      exp_drop = 0;
      if (x.rst) begin
         clear_model();
         m_cap = 0;
         last_pkt = zero_pkt();
      end else begin
         if (m_cap && x.dn && !x.st) begin
            record(x);
            last_pkt = build(x.rg);
            exp_valid = 1;
            m_cap = 0;
         end else if (m_cap && x.dn && x.st) begin
            last_pkt = build(x.rg);
            exp_valid = 1;
         end else if (m_cap && x.st) begin
            exp_drop = 1;
         end else if (m_cap) begin
            record(x);
         end
         if (x.st) begin
            clear_model();
            m_regs_in = x.rg;
            record(x);
            m_cap = 1;
         end
      end
      #1;
      checkPacket();
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      m_cap = 0;
      last_pkt = zero_pkt();

      // Reset: all outputs zero.
      c = idle_cyc(); c.rst = 1;
      applyStimulus(c);
      applyStimulus(c);
      checkOutput("reset_valid", 256'(z80fi_valid), 256'(0));
      checkOutput("reset_insn",  256'(z80fi_insn), 256'(0));

      // PUSH IX
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'hDD;
      c.rg[16*REG_SP +: 16] = 16'hFFFE; c.rg[16*REG_IX +: 16] = 16'h1234;
      applyStimulus(c);
      c = idle_cyc(); c.fv = 1; c.fb = 8'hE5; applyStimulus(c);
      c = idle_cyc(); c.w = 1; c.wa = 16'hFFFC; c.wd = 8'h34; applyStimulus(c);
      c = idle_cyc(); c.w = 1; c.wa = 16'hFFFD; c.wd = 8'h12; c.dn = 1;
      c.rg[16*REG_SP +: 16] = 16'hFFFC;
      applyStimulus(c);
      checkOutput("push_valid", 256'(z80fi_valid), 256'(1));
      checkOutput("push_insn",  256'(z80fi_insn), 256'(32'h0000E5DD));
      checkOutput("push_len",   256'(z80fi_insn_len), 256'(3'd2));
      checkOutput("push_wr",    256'({z80fi_mem_wr, z80fi_mem_wr2, z80fi_mem_waddr, z80fi_mem_wdata,
                                      z80fi_mem_waddr2, z80fi_mem_wdata2}),
                  256'({1'b1, 1'b1, 16'hFFFC, 8'h34, 16'hFFFD, 8'h12}));
      checkOutput("push_sp_in",  256'(z80fi_regs_in[16*REG_SP +: 16]), 256'(16'hFFFE));
      checkOutput("push_ix_in",  256'(z80fi_regs_in[16*REG_IX +: 16]), 256'(16'h1234));
      checkOutput("push_sp_out", 256'(z80fi_regs_out[16*REG_SP +: 16]), 256'(16'hFFFC));
      checkOutput("push_rd",    256'(z80fi_mem_rd), 256'(0));
      c = idle_cyc(); applyStimulus(c);

      // Back-to-back: NOP retires as LD A,n starts.
      r1 = rand_regs(); r2 = rand_regs(); r3 = rand_regs();
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'h00; c.rg = r1; applyStimulus(c);
      c = idle_cyc(); c.st = 1; c.dn = 1; c.fv = 1; c.fb = 8'h3E; c.rg = r2; applyStimulus(c);
      checkOutput("b2b_valid1", 256'(z80fi_valid), 256'(1));
      checkOutput("b2b_insn1",  256'(z80fi_insn), 256'(32'h0));
      checkOutput("b2b_len1",   256'(z80fi_insn_len), 256'(3'd1));
      checkOutput("b2b_rout1",  256'(z80fi_regs_out), 256'(r2));
      c = idle_cyc(); c.fv = 1; c.fb = 8'h55; c.dn = 1; c.rg = r3; applyStimulus(c);
      checkOutput("b2b_valid2", 256'(z80fi_valid), 256'(1));
      checkOutput("b2b_insn2",  256'(z80fi_insn), 256'(32'h0000553E));
      checkOutput("b2b_len2",   256'(z80fi_insn_len), 256'(3'd2));
      checkOutput("b2b_rin2",   256'(z80fi_regs_in), 256'(r2));
      c = idle_cyc(); applyStimulus(c);

      // Overflow: five fetches and three writes.
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'hDD; c.w = 1; c.wa = 16'h1000; c.wd = 8'hA1;
      applyStimulus(c);
      c = idle_cyc(); c.fv = 1; c.fb = 8'hCB; c.w = 1; c.wa = 16'h1001; c.wd = 8'hA2; applyStimulus(c);
      c = idle_cyc(); c.fv = 1; c.fb = 8'h05; c.w = 1; c.wa = 16'h1002; c.wd = 8'hA3; applyStimulus(c);
      c = idle_cyc(); c.fv = 1; c.fb = 8'hC6; applyStimulus(c);
      c = idle_cyc(); c.fv = 1; c.fb = 8'hFF; c.dn = 1; applyStimulus(c);
      checkOutput("ovf_len",  256'(z80fi_insn_len), 256'(3'd4));
      checkOutput("ovf_insn", 256'(z80fi_insn), 256'(32'hC605CBDD));
      checkOutput("ovf_wr",   256'({z80fi_mem_waddr, z80fi_mem_wdata, z80fi_mem_waddr2, z80fi_mem_wdata2}),
                  256'({16'h1000, 8'hA1, 16'h1001, 8'hA2}));
      checkOutput("ovf_flag", 256'(z80fi_overflow), 256'(1));
      c = idle_cyc(); applyStimulus(c);

      // Abandon: a second start without done drops the first instruction.
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'hDD; applyStimulus(c);
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'h01; applyStimulus(c);
      checkOutput("abandon_drop",  256'(z80fi_dropped), 256'(1));
      checkOutput("abandon_valid", 256'(z80fi_valid), 256'(0));
      c = idle_cyc(); c.fv = 1; c.fb = 8'h02; c.dn = 1; applyStimulus(c);
      checkOutput("abandon_drop_end", 256'(z80fi_dropped), 256'(0));
      checkOutput("abandon_insn", 256'(z80fi_insn), 256'(32'h00000201));
      checkOutput("abandon_len",  256'(z80fi_insn_len), 256'(3'd2));

      // Reset coinciding with retirement, reset mid-capture, then stray done in IDLE.
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'h11; applyStimulus(c);
      c = idle_cyc(); c.dn = 1; c.rst = 1; applyStimulus(c);
      checkOutput("rst_done_valid", 256'(z80fi_valid), 256'(0));
      checkOutput("rst_done_insn",  256'(z80fi_insn), 256'(0));
      c = idle_cyc(); c.st = 1; c.fv = 1; c.fb = 8'h22; applyStimulus(c);
      c = idle_cyc(); c.rst = 1; applyStimulus(c);
      checkOutput("rst_mid_drop", 256'(z80fi_dropped), 256'(0));
      c = idle_cyc(); c.dn = 1; c.fv = 1; c.fb = 8'h33; applyStimulus(c);
      checkOutput("stray_done_valid", 256'(z80fi_valid), 256'(0));

      // Random cycles against the model.
      for (int n = 0; n < 600; n++) begin
         c = idle_cyc();
         c.rst  = ($urandom_range(0, 79) == 0);
         c.st   = ($urandom_range(0, 3) == 0);
         c.dn   = ($urandom_range(0, 3) == 0);
         c.fv   = ($urandom_range(0, 1) == 0);
         c.fb   = 8'($urandom);
         c.w    = ($urandom_range(0, 3) == 0);
         c.wa   = 16'($urandom);
         c.wd   = 8'($urandom);
         c.r    = ($urandom_range(0, 3) == 0);
         c.ra   = 16'($urandom);
         c.rdat = 8'($urandom);
         applyStimulus(c);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
